// File: rtl/shift_register_univ.sv
// Universal shift register: hold, shift right/left (serial-in or rotate) and
// parallel load, with a modulo-WIDTH shift counter and a registered frame-done pulse.
module shift_register_univ #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [1:0]               mode,
  input  logic                     rot,
  input  logic                     si,
  input  logic [WIDTH-1:0]         d,
  output logic [WIDTH-1:0]         y,
  output logic                     so_r,
  output logic                     so_l,
  output logic [$clog2(WIDTH)-1:0] cnt,
  output logic                     frame_done
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] MODE_HOLD    = 2'b00;
  localparam logic [1:0] MODE_SHIFT_R = 2'b01;
  localparam logic [1:0] MODE_SHIFT_L = 2'b10;
  localparam logic [1:0] MODE_LOAD    = 2'b11;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] y_q, y_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             shift;

  always_comb begin
    y_d    = y_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    shift  = 1'b0;
    if (en) begin
      case (mode)
        MODE_SHIFT_R: begin
          y_d   = {(rot ? y_q[0] : si), y_q[WIDTH-1:1]};
          shift = 1'b1;
        end
        MODE_SHIFT_L: begin
          y_d   = {y_q[WIDTH-2:0], (rot ? y_q[WIDTH-1] : si)};
          shift = 1'b1;
        end
        MODE_LOAD: begin
          y_d   = d;
          cnt_d = '0;
        end
        default: ;
      endcase
    end
    // Explicit wrap keeps the count modulo WIDTH even when WIDTH is not a power of two.
    if (shift) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q    <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      y_q    <= y_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign y          = y_q;
  assign so_r       = y_q[0];
  assign so_l       = y_q[WIDTH-1];
  assign cnt        = cnt_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_shift_register_univ.sv
// Table-driven bench for shift_register_univ at WIDTH=8, plus a SIPO sweep at
// WIDTH=2 and WIDTH=16; expected results flow through scoreboard queues.
module tb_shift_register_univ;

  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] SR   = 2'b01;
  localparam logic [1:0] SL   = 2'b10;
  localparam logic [1:0] LD   = 2'b11;

  logic        clk = 1'b0;
  logic        rst, en, rot, si;
  logic [1:0]  mode;
  logic [7:0]  d8;
  logic [1:0]  d2;
  logic [15:0] d16;

  logic [7:0]  y8;
  logic [1:0]  y2;
  logic [15:0] y16;
  logic        so_r8, so_l8, so_r2, so_l2, so_r16, so_l16;
  logic [2:0]  cnt8;
  logic [0:0]  cnt2;
  logic [3:0]  cnt16;
  logic        done8, done2, done16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_register_univ #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .rot(rot), .si(si), .d(d8),
    .y(y8), .so_r(so_r8), .so_l(so_l8), .cnt(cnt8), .frame_done(done8)
  );

  shift_register_univ #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .rot(rot), .si(si), .d(d2),
    .y(y2), .so_r(so_r2), .so_l(so_l2), .cnt(cnt2), .frame_done(done2)
  );

  shift_register_univ #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .rot(rot), .si(si), .d(d16),
    .y(y16), .so_r(so_r16), .so_l(so_l16), .cnt(cnt16), .frame_done(done16)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       rot;
    logic       si;
    logic [7:0] d;
    logic [7:0] y;
    logic [2:0] cnt;
    logic       done;
  } vec_t;

  typedef struct {
    logic [15:0] y;
    logic [3:0]  cnt;
    logic        done;
  } exp_t;

  vec_t vecs[$];
  exp_t sb8[$];
  exp_t sb2[$];
  exp_t sb16[$];

  function automatic void add(input logic r, input logic e, input logic [1:0] m,
                              input logic ro, input logic s, input logic [7:0] dv,
                              input logic [7:0] ey, input logic [2:0] ec, input logic ed);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.rot = ro; v.si = s; v.d = dv;
    v.y = ey; v.cnt = ec; v.done = ed;
    vecs.push_back(v);
  endfunction

  task automatic check_output(input string name, input int step,
                              input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s step %0d: got %0h expected %0h", name, step, act, exp_v);
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic e, input logic [1:0] m,
                                input logic ro, input logic s, input logic [7:0] dv);
    @(negedge clk);
    rst = r; en = e; mode = m; rot = ro; si = s;
    d8 = dv; d2 = '0; d16 = '0;
  endtask

  task automatic check_dut8(input int step);
    exp_t e;
    if (sb8.size() == 0) begin
      checks++; errors++;
      $display("[TB] FAIL sb8_empty step %0d: got 0 entries expected 1", step);
    end else begin
      e = sb8.pop_front();
      check_output("y8", step, 32'(y8), 32'(e.y[7:0]));
      check_output("so_r8", step, 32'(so_r8), 32'(e.y[0]));
      check_output("so_l8", step, 32'(so_l8), 32'(e.y[7]));
      check_output("cnt8", step, 32'(cnt8), 32'(e.cnt[2:0]));
      check_output("done8", step, 32'(done8), 32'(e.done));
    end
  endtask

  task automatic check_sweep(input int step);
    exp_t e2, e16;
    if (sb2.size() == 0 || sb16.size() == 0) begin
      checks++; errors++;
      $display("[TB] FAIL sb_sweep_empty step %0d: got 0 entries expected 1", step);
    end else begin
      e2  = sb2.pop_front();
      e16 = sb16.pop_front();
      check_output("y2", step, 32'(y2), 32'(e2.y[1:0]));
      check_output("so_l2", step, 32'(so_l2), 32'(e2.y[1]));
      check_output("cnt2", step, 32'(cnt2), 32'(e2.cnt[0]));
      check_output("done2", step, 32'(done2), 32'(e2.done));
      check_output("y16", step, 32'(y16), 32'(e16.y));
      check_output("so_r16", step, 32'(so_r16), 32'(e16.y[0]));
      check_output("cnt16", step, 32'(cnt16), 32'(e16.cnt));
      check_output("done16", step, 32'(done16), 32'(e16.done));
    end
  endtask

  initial begin
    exp_t        e;
    logic [1:0]  m2;
    logic [15:0] m16;
    logic [7:0]  pat;
    logic        bit_in;

    rst = 1'b1; en = 1'b0; mode = HOLD; rot = 1'b0; si = 1'b0;
    d8 = '0; d2 = '0; d16 = '0;

    // Reset, including reset overriding an enabled LOAD
    add(1, 0, HOLD, 0, 0, 8'h00, 8'h00, 0, 0);
    add(0, 1, LD,   0, 0, 8'hA5, 8'hA5, 0, 0);
    add(1, 0, HOLD, 0, 0, 8'h00, 8'h00, 0, 0);
    add(0, 1, LD,   0, 0, 8'hA5, 8'hA5, 0, 0);
    add(1, 1, LD,   0, 0, 8'hFF, 8'h00, 0, 0);
    // SIPO, si = 1,0,1,1,0,0,1,0
    add(0, 1, SR, 0, 1, 8'h00, 8'h80, 1, 0);
    add(0, 1, SR, 0, 0, 8'h00, 8'h40, 2, 0);
    add(0, 1, SR, 0, 1, 8'h00, 8'hA0, 3, 0);
    add(0, 1, SR, 0, 1, 8'h00, 8'hD0, 4, 0);
    add(0, 1, SR, 0, 0, 8'h00, 8'h68, 5, 0);
    add(0, 1, SR, 0, 0, 8'h00, 8'h34, 6, 0);
    add(0, 1, SR, 0, 1, 8'h00, 8'h9A, 7, 0);
    add(0, 1, SR, 0, 0, 8'h00, 8'h4D, 0, 1);
    add(0, 1, HOLD, 1, 1, 8'hFF, 8'h4D, 0, 0);
    // PISO from 8'h81
    add(0, 1, LD, 0, 0, 8'h81, 8'h81, 0, 0);
    add(0, 1, SL, 0, 0, 8'h00, 8'h02, 1, 0);
    add(0, 1, SL, 0, 0, 8'h00, 8'h04, 2, 0);
    add(0, 1, SL, 0, 0, 8'h00, 8'h08, 3, 0);
    add(0, 1, SL, 0, 0, 8'h00, 8'h10, 4, 0);
    add(0, 1, SL, 0, 0, 8'h00, 8'h20, 5, 0);
    add(0, 1, SL, 0, 0, 8'h00, 8'h40, 6, 0);
    add(0, 1, SL, 0, 0, 8'h00, 8'h80, 7, 0);
    add(0, 1, SL, 0, 0, 8'h00, 8'h00, 0, 1);
    // Two back-to-back rotate frames; si chosen to differ from the recirculated bit
    add(0, 1, LD, 0, 0, 8'h01, 8'h01, 0, 0);
    add(0, 1, SR, 1, 0, 8'h00, 8'h80, 1, 0);
    add(0, 1, SR, 1, 0, 8'h00, 8'h40, 2, 0);
    add(0, 1, SR, 1, 0, 8'h00, 8'h20, 3, 0);
    add(0, 1, SR, 1, 0, 8'h00, 8'h10, 4, 0);
    add(0, 1, SR, 1, 0, 8'h00, 8'h08, 5, 0);
    add(0, 1, SR, 1, 0, 8'h00, 8'h04, 6, 0);
    add(0, 1, SR, 1, 0, 8'h00, 8'h02, 7, 0);
    add(0, 1, SR, 1, 0, 8'h00, 8'h01, 0, 1);
    add(0, 1, SR, 1, 1, 8'h00, 8'h80, 1, 0);
    add(0, 1, SR, 1, 1, 8'h00, 8'h40, 2, 0);
    add(0, 1, SR, 1, 1, 8'h00, 8'h20, 3, 0);
    add(0, 1, SR, 1, 1, 8'h00, 8'h10, 4, 0);
    add(0, 1, SR, 1, 1, 8'h00, 8'h08, 5, 0);
    add(0, 1, SR, 1, 1, 8'h00, 8'h04, 6, 0);
    add(0, 1, SR, 1, 1, 8'h00, 8'h02, 7, 0);
    add(0, 1, SR, 1, 1, 8'h00, 8'h01, 0, 1);
    add(0, 1, LD, 1, 1, 8'h3C, 8'h3C, 0, 0);
    // Enable low holds mid-frame, then reset discards the partial count
    add(1, 0, HOLD, 0, 0, 8'h00, 8'h00, 0, 0);
    add(0, 1, SR, 0, 1, 8'h00, 8'h80, 1, 0);
    add(0, 1, SR, 0, 1, 8'h00, 8'hC0, 2, 0);
    add(0, 1, SR, 0, 1, 8'h00, 8'hE0, 3, 0);
    add(0, 0, SR, 0, 1, 8'h00, 8'hE0, 3, 0);
    add(0, 0, SL, 1, 0, 8'h00, 8'hE0, 3, 0);
    add(0, 0, LD, 0, 1, 8'hFF, 8'hE0, 3, 0);
    add(0, 0, SR, 1, 1, 8'h00, 8'hE0, 3, 0);
    add(1, 1, SR, 0, 1, 8'h00, 8'h00, 0, 0);
    add(0, 1, SL, 0, 1, 8'h00, 8'h01, 1, 0);
    add(0, 1, SL, 0, 1, 8'h00, 8'h03, 2, 0);
    add(0, 1, SL, 0, 1, 8'h00, 8'h07, 3, 0);
    add(0, 1, SL, 0, 1, 8'h00, 8'h0F, 4, 0);
    add(0, 1, SR, 0, 0, 8'h00, 8'h07, 5, 0);
    add(0, 1, SR, 0, 0, 8'h00, 8'h03, 6, 0);
    add(0, 1, SR, 0, 0, 8'h00, 8'h01, 7, 0);
    add(0, 1, SL, 0, 0, 8'h00, 8'h02, 0, 1);
    // Reset on a would-be completing shift suppresses the pulse
    add(0, 1, SR, 1, 0, 8'h00, 8'h01, 1, 0);
    add(0, 1, SR, 1, 0, 8'h00, 8'h80, 2, 0);
    add(0, 1, SR, 1, 0, 8'h00, 8'h40, 3, 0);
    add(0, 1, SR, 1, 0, 8'h00, 8'h20, 4, 0);
    add(0, 1, SR, 1, 0, 8'h00, 8'h10, 5, 0);
    add(0, 1, SR, 1, 0, 8'h00, 8'h08, 6, 0);
    add(0, 1, SR, 1, 0, 8'h00, 8'h04, 7, 0);
    add(1, 1, SR, 1, 0, 8'h00, 8'h00, 0, 0);
    add(0, 1, HOLD, 0, 0, 8'h00, 8'h00, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].rot, vecs[i].si, vecs[i].d);
      e.y = {8'h00, vecs[i].y}; e.cnt = {1'b0, vecs[i].cnt}; e.done = vecs[i].done;
      sb8.push_back(e);
      @(posedge clk); #1;
      check_dut8(i);
    end

    // SIPO sweep at WIDTH=2 and WIDTH=16 over two 16-bit frames
    pat = 8'b0100_1101;
    m2  = '0;
    m16 = '0;
    apply_stimulus(1, 0, HOLD, 0, 0, 8'h00);
    e.y = 16'h0000; e.cnt = 4'd0; e.done = 1'b0;
    sb2.push_back(e);
    sb16.push_back(e);
    @(posedge clk); #1;
    check_sweep(0);

    for (int k = 1; k <= 32; k++) begin
      bit_in = pat[(k - 1) % 8];
      apply_stimulus(0, 1, SR, 0, bit_in, 8'h00);
      m2  = {bit_in, m2[1]};
      m16 = {bit_in, m16[15:1]};
      e.y = {14'h0, m2}; e.cnt = 4'(k % 2); e.done = ((k % 2) == 0);
      sb2.push_back(e);
      e.y = m16; e.cnt = 4'(k % 16); e.done = ((k % 16) == 0);
      sb16.push_back(e);
      @(posedge clk); #1;
      check_sweep(k);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_register_univ.md
# shift_register_univ

Parametrised universal shift register: the next generation of the team's 8-bit serial-in shift register. It adds configurable width, four operating modes (hold, shift right, shift left, parallel load), optional rotation, and a shift counter with a frame-complete pulse. This lets the block act as SIPO, PISO or ring register in serial links and test datapaths. It sits between a serial pin/bit stream and a parallel bus.

## Interface
Parameters:
- WIDTH, 8, register width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  clock enable; en=0 behaves exactly as mode HOLD.
- mode  input  2  00 HOLD, 01 SHIFT_R, 10 SHIFT_L, 11 LOAD.
- rot  input  1  1 = rotate (outgoing bit re-enters), 0 = serial input enters; ignored in HOLD/LOAD.
- si  input  1  serial data in.
- d  input  WIDTH  parallel load data.
- y  output  WIDTH  register contents.
- so_r  output  1  y[0], combinational from the register.
- so_l  output  1  y[WIDTH-1], combinational from the register.
- cnt  output  $clog2(WIDTH)  number of shifts since the last load or reset, modulo WIDTH.
- frame_done  output  1  one-cycle pulse: WIDTH shifts have completed.

## Operation
- Reset (rst=1 at a rising edge) has priority over everything, including en:
  - y=0, cnt=0, frame_done=0.
  - so_r=so_l=0 follow from y.
- All state updates occur only at the rising edge of clk.
- HOLD (or en=0): y and cnt unchanged; frame_done=0.
- SHIFT_R, y moves toward the LSB:
  - rot=0: y <= {si, y[WIDTH-1:1]}, so si enters at the MSB (same direction as the 8-bit predecessor).
  - rot=1: y <= {y[0], y[WIDTH-1:1]}.
- SHIFT_L, y moves toward the MSB:
  - rot=0: y <= {y[WIDTH-2:0], si}.
  - rot=1: y <= {y[WIDTH-2:0], y[WIDTH-1]}.
- LOAD: y <= d; cnt <= 0; frame_done <= 0.
- Shift counter:
  - Every SHIFT_R/SHIFT_L cycle with en=1 increments cnt, regardless of rot or direction.
  - When cnt == WIDTH-1 and a shift occurs:
    - cnt wraps to 0.
    - frame_done is 1 in the following cycle, concurrent with y holding the completed frame.
  - Otherwise frame_done=0.
- Direction changes mid-frame do not reset cnt; only LOAD and rst do.
- Two back-to-back complete frames (2*WIDTH consecutive shifts) produce two frame_done pulses exactly WIDTH cycles apart.
- rot has no effect in HOLD or LOAD.
- si and d are don't-care when not used by the selected mode.

## Timing
- Latency: one clock from an input sample to the updated y; so_r/so_l change in the same cycle as y.
- frame_done is registered. It is high for exactly one cycle, the cycle after the WIDTH-th shift edge.
- Reset mid-frame:
  - Discards the partial count; the next frame needs a full WIDTH shifts.
  - A frame_done due in the reset cycle is suppressed.
- LOAD on the cycle after a completing shift: frame_done is still 1 that cycle (it reflects the previous edge). It is cleared by the LOAD edge.
- Input setup/hold: synchronous to clk. No combinational path from inputs to outputs.

## Test plan
- Reset: drive random y via LOAD d=8'hA5, then rst=1 for one edge -> y=8'h00, cnt=0, frame_done=0. Also rst=1 with en=1, mode=LOAD, d=8'hFF -> y stays 8'h00.
- SIPO: WIDTH=8, mode=SHIFT_R, rot=0, si sequence 1,0,1,1,0,0,1,0 (first bit first) -> y=8'b01001101 after 8 edges.
  - frame_done=1 exactly in the cycle after the 8th edge; cnt=0 then.
- PISO: LOAD d=8'h81, then 8 SHIFT_L with rot=0, si=0 -> so_l sequence 1,0,0,0,0,0,0,1 (from load cycle onward), y=8'h00 at end.
- Rotate: LOAD d=8'h01, then 8 SHIFT_R with rot=1 -> y walks 80,40,20,10,08,04,02,01.
  - frame_done pulses once.
  - 8 further rotates -> second pulse exactly 8 cycles after the first.
- Enable/hold and mid-frame reset:
  - 3 shifts with si=1, then en=0 for 4 cycles -> y=8'hE0, cnt=3 unchanged.
  - Then rst -> cnt=0; the next 7 shifts give no frame_done; the 8th gives the pulse.
- Parameter sweep: repeat the SIPO test at WIDTH=2 and WIDTH=16.
  - frame_done after 2 and 16 shifts respectively.
  - cnt wraps at WIDTH-1.
